// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus/timeout sizing
// for the APB master and slave blocks.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH     = 4;
  localparam int unsigned APB_DATA_WIDTH     = 32;
  localparam int unsigned APB_TIMEOUT_CYCLES = 16;

  // Wide enough for the largest legal TIMEOUT_CYCLES (255)
  localparam int unsigned APB_WAIT_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts stalled ACCESS cycles and flags the cycle on which the transfer
// must be abandoned if the slave is still not ready.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [APB_WAIT_CNT_WIDTH-1:0] LastCount =
    APB_WAIT_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [APB_WAIT_CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LastCount)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LastCount);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: accepts one command in IDLE, runs the
// SETUP/ACCESS handshake and reports completion or timeout with a 1-cycle pulse.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  apb_state_e state_q, state_d;

  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic accept;
  logic busy;
  logic done;
  logic abort;
  logic wait_expired;

  assign accept = cmd_valid && (state_q == IDLE);
  assign busy   = (state_q != IDLE);

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .clear  (state_q == SETUP),
    .enable ((state_q == ACCESS) && !PREADY),
    .expired(wait_expired)
  );

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A ready slave wins even on the last permitted cycle
        if (PREADY) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (wait_expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rsp_valid_d   = done || abort;
    rsp_timeout_d = abort;
    rsp_rdata_d   = (done && !write_q) ? PRDATA : '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      if (accept) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;

  // Bus is forced quiet in IDLE regardless of the last captured command
  assign PSEL    = busy;
  assign PENABLE = (state_q == ACCESS);
  assign PWRITE  = busy && write_q;
  assign PADDR   = busy ? addr_q : '0;
  assign PWDATA  = busy ? wdata_q : '0;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 4, APB address width; DATA_WIDTH, default 32, APB data width; TIMEOUT_CYCLES, default 16, maximum ACCESS-phase cycles before abort (legal range 2..255).
REQ-002 Ports SHALL be, in order:
- PCLK in 1: clock.
- PRESETn in 1: reset, asynchronous, active-low.
- cmd_valid in 1: command request.
- cmd_ready out 1: command accepted when high with cmd_valid.
- cmd_write in 1: 1=write, 0=read.
- cmd_addr in ADDR_WIDTH: target address.
- cmd_wdata in DATA_WIDTH: write data.
- rsp_valid out 1: one-cycle completion pulse.
- rsp_rdata out DATA_WIDTH: read data.
- rsp_timeout out 1: transfer aborted.
- PSEL out 1: peripheral select.
- PENABLE out 1: access phase.
- PWRITE out 1: write control.
- PADDR out ADDR_WIDTH: address bus.
- PWDATA out DATA_WIDTH: write data bus.
- PRDATA in DATA_WIDTH: read data bus.
- PREADY in 1: slave ready.
REQ-003 The block SHALL use one clock (PCLK) with asynchronous active-low reset (PRESETn).

Function
REQ-004 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-005 cmd_ready SHALL equal (state==IDLE); the command SHALL be accepted only in IDLE, with no backpressure on responses.
REQ-006 On the PCLK edge where cmd_valid&&cmd_ready, cmd_write/cmd_addr/cmd_wdata SHALL be captured, and the FSM SHALL enter SETUP.
REQ-007 In SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = captured values; the FSM SHALL move to ACCESS after exactly one cycle.
REQ-008 In ACCESS: PSEL=1, PENABLE=1, PADDR/PWRITE/PWDATA SHALL be held stable, identical to SETUP.
REQ-009 In IDLE: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
REQ-010 On an ACCESS-cycle edge with PREADY=1, the FSM SHALL return to IDLE, and on that edge:
- rsp_valid<=1.
- rsp_timeout<=0.
- rsp_rdata<=PRDATA for reads, 0 for writes.
REQ-011 rsp_valid SHALL be high for exactly one cycle (the first IDLE cycle); rsp_rdata and rsp_timeout SHALL return to 0 when rsp_valid is low.
REQ-012 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-013 Timeout SHALL fire on an ACCESS cycle where PREADY=0 and the counter equals TIMEOUT_CYCLES-1, so ACCESS lasts at most TIMEOUT_CYCLES cycles. On that edge:
- The FSM SHALL go to IDLE.
- rsp_valid<=1.
- rsp_timeout<=1.
- rsp_rdata<=0.
REQ-014 PREADY=1 on the final permitted ACCESS cycle SHALL complete normally; success SHALL take priority over timeout.
REQ-015 Minimum transfer spacing SHALL be 3 cycles (IDLE, SETUP, ACCESS); cmd_valid asserted while busy SHALL be ignored until IDLE.
REQ-016 All outputs except cmd_ready SHALL be registered or decoded from registered state only; there SHALL be no combinational path from PREADY/PRDATA to any output.

Reset
REQ-017 Assertion of PRESETn SHALL immediately force state=IDLE, all APB outputs 0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, wait counter=0, and captured command=0.
REQ-018 Reset during SETUP or ACCESS SHALL abort the transfer with no response pulse; after reset release cmd_ready SHALL be 1.

Structure
REQ-019 A shared package apb_pkg SHALL hold the state enum apb_state_e {IDLE, SETUP, ACCESS} and the default width/timeout constants used by apb_master and apb_slave.
REQ-020 The wait counter and timeout compare SHALL be a sub-module apb_wait_timer (ports: clk, rst_n, clear, enable, expired; parameter TIMEOUT_CYCLES).

Verification
REQ-021 Write, slave PREADY=1: cmd write addr 0x2 data 0xDEADBEEF -> PSEL=1 cycle+1, PENABLE=1 cycle+2, rsp_valid=1 cycle+3 with rsp_timeout=0 and rsp_rdata=0; slave register 2 = 0xDEADBEEF.
REQ-022 Read-back: cmd read addr 0x2 -> rsp_valid one cycle with rsp_rdata=0xDEADBEEF.
REQ-023 Wait states: PREADY held 0 for 3 ACCESS cycles -> PENABLE high 4 cycles; PADDR/PWDATA/PWRITE stable throughout; single rsp_valid pulse, rsp_timeout=0.
REQ-024 Timeout, TIMEOUT_CYCLES=16, PREADY stuck 0 -> PENABLE high exactly 16 cycles, then PSEL=0 and rsp_valid=1, rsp_timeout=1, rsp_rdata=0. Variant with PREADY=1 on the 16th ACCESS cycle -> normal completion, rsp_timeout=0.
REQ-025 Reset mid-ACCESS: PRESETn low asynchronously -> PSEL/PENABLE=0 before next edge; no rsp_valid; cmd_ready=1 after release.
REQ-026 Busy command: cmd_valid held high with new data during SETUP/ACCESS -> cmd_ready=0; command captured only in the next IDLE cycle; the first transfer's PADDR/PWDATA are unchanged.
